pw_sequencer: RTL and testbench
===============================

# pw_sequencer

Segment scheduler for the square-wave output. Holds a small table of (half-period, toggle-count) segments and plays them back in order on `sig_out`, optionally looping, with a per-segment boundary strobe `com`. It replaces a fixed-period toggle counter wherever the team needs programmable waveform sequences gated by the clock-wizard `locked` signal.

## Interface
- `CNT_W`, 24: width of the half-period field and of the cycle counter.
- `REP_W`, 16: width of the toggle-count field and of the toggle counter.
- `DEPTH`, 4: number of table entries; power of 2, at least 2. `AW = $clog2(DEPTH)`.
- `IDLE_LEVEL`, 1'b1: level driven on `sig_out` at reset, on stop and on abort.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `locked`  in  1  clock-good; a run starts and continues only while it is high.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  AW  table entry index.
- `cfg_half`  in  CNT_W  half-period value H; the half-period is H+1 cycles.
- `cfg_rep`  in  REP_W  toggles in the segment; 0 is treated as 1.
- `cfg_last`  in  AW  index of the last segment; sampled live, hold stable while busy.
- `loop_en`  in  1  1 = wrap from `cfg_last` back to entry 0; sampled at each wrap decision.
- `start`  in  1  one-cycle request to begin a run.
- `stop`  in  1  one-cycle request to end a run.
- `sig_out`  out  1  registered waveform output.
- `com`  out  1  one-cycle pulse on each segment's final toggle.
- `seg_idx`  out  AW  index of the active segment.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on natural completion (loop off).
- `err`  out  1  one-cycle pulse on abort or on a rejected write.

## Operation
- Reset values: `sig_out`=IDLE_LEVEL; `com`, `busy`, `done` and `err` = 0; `seg_idx`=0; all table entries = 0 (H=0, rep=0). The state is IDLE.
- The table is register-based and read combinationally at `seg_idx`. Writes are accepted only in IDLE. `cfg_we` in RUN leaves the table unchanged and pulses `err`.
- IDLE:
  - `start`=1, `locked`=1 and `stop`=0 moves to RUN. On entry: `seg_idx`=0, cycle counter=0, toggle counter=0, `sig_out` forced to IDLE_LEVEL.
  - `start` with `locked`=0 is ignored; no `err`.
- RUN:
  - Cycle counter increments each cycle.
  - When the counter equals H[seg_idx]: counter returns to 0, `sig_out` toggles and the toggle counter increments.
  - On the toggle that reaches rep (rep of 0 counts as 1), `com`=1 and the toggle counter returns to 0.
  - If `seg_idx` != `cfg_last`, `seg_idx`+1.
  - Else if `loop_en`=1, `seg_idx`=0.
  - Else `done`=1 and the state returns to IDLE; `sig_out` holds its final level.
- `stop` in RUN: next state IDLE, `sig_out`=IDLE_LEVEL, `seg_idx`=0, no `com` or `done`. `stop` takes priority over a terminal toggle in the same cycle.
- `locked`=0 in RUN: same as `stop`, plus `err`=1 for one cycle. If `stop` and `locked`=0 occur together, `err` is still pulsed.
- `start` while busy: ignored.
- Counter widths: there is no overflow, because the counter is compared against H before wrapping.

## Timing
- `start` sampled at edge k: `busy`=1 after edge k. The first `sig_out` toggle occurs at edge k+H0+1; later toggles follow every H+1 cycles of the active segment.
- There is no bubble between segments. The first toggle of segment n+1 comes exactly H(n+1)+1 cycles after the final toggle of segment n.
- `com`, `done`, the `seg_idx` update and `busy` falling all register on the same edge as the terminal toggle.
- `stop` or `locked` low at edge j: `busy`=0 and `sig_out`=IDLE_LEVEL after edge j; `err` is high for the cycle after edge j.
- A new `start` is accepted in the cycle immediately after `done`.
- Asynchronous `rst` mid-run returns every output to its reset value immediately and clears the table.

## Test plan
- Reset: hold `rst`=0, toggle `clk`. All outputs stay at their reset values; a read-back run of entry 0 gives one toggle at edge k+1.
- Single segment, with CNT_W=8, REP_W=4: entry 0 = H=3, rep=2; `cfg_last`=0; `loop_en`=0; `start` at edge 0. Toggles at edges 4 and 8 (1→0→1). `com` and `done` at edge 8. `busy` low after edge 8.
- Looping: entry 0 = H=1, rep=2; entry 1 = H=2, rep=1; `cfg_last`=1; `loop_en`=1. Toggles at edges 2, 4, 7, 9, 11, 14. `com` at 4, 7, 11, 14. `seg_idx` goes 0→1 at 4 and 1→0 at 7. `done` never asserts.
- Stop: assert `stop` at edge 3 of the single-segment case. `sig_out`=1, `busy`=0, no `com`/`done`. Repeat with `stop` at edge 8: `stop` wins, no `com` or `done`.
- Abort and write rejection: drop `locked` mid-run. `err` pulses, `sig_out`=IDLE_LEVEL. Issue `cfg_we` to entry 1 while busy: `err` pulses and a later run shows the old entry 1.
- rep=0: entry 0 = H=2, rep=0. One toggle at edge 3 with `com` and `done` at edge 3.

Source files
------------

// File: rtl/pw_sequencer.sv
// ---------------------------------------------------------------------------
// pw_sequencer
//
// Square-wave segment scheduler. A small register table holds
// (half-period, toggle-count) pairs. A run plays the entries back in order on
// sig_out, starting at entry 0 and ending at cfg_last. When loop_en is set,
// the run wraps back to entry 0 instead of ending. A run starts and continues
// only while the clock-wizard locked input is high.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous reset, active low
//   locked    in   clock-good qualifier for starting and sustaining a run
//   cfg_we    in   table write strobe (accepted only while idle)
//   cfg_addr  in   table entry index for writes
//   cfg_half  in   half-period value H; the half-period is H+1 cycles
//   cfg_rep   in   toggles per segment; 0 behaves as 1
//   cfg_last  in   index of the final segment (sampled live)
//   loop_en   in   wrap from cfg_last to entry 0 instead of finishing
//   start     in   one-cycle run request
//   stop      in   one-cycle run termination request
//   sig_out   out  registered waveform
//   com       out  one-cycle pulse on each segment's final toggle
//   seg_idx   out  active segment index
//   busy      out  high while a run is in progress
//   done      out  one-cycle pulse on natural completion
//   err       out  one-cycle pulse on abort (locked lost) or rejected write
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for start; table writable; sig_out holds its level
//   S_RUN  | playing segments; table write-protected
// ---------------------------------------------------------------------------
module pw_sequencer #(
    parameter int   CNT_W      = 24,
    parameter int   REP_W      = 16,
    parameter int   DEPTH      = 4,
    parameter logic IDLE_LEVEL = 1'b1,
    localparam int  AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [REP_W-1:0] cfg_rep,
    input  logic [AW-1:0]    cfg_last,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic             sig_out,
    output logic             com,
    output logic [AW-1:0]    seg_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [CNT_W-1:0] half_tab [DEPTH];
    logic [REP_W-1:0] rep_tab  [DEPTH];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [REP_W-1:0] tcnt;
    logic [REP_W-1:0] tcnt_n;
    logic [AW-1:0]    seg_n;
    logic             sig_n;
    logic             com_n;
    logic             done_n;
    logic             err_n;

    logic [CNT_W-1:0] cur_half;
    logic [REP_W-1:0] cur_rep;
    logic             half_hit;
    logic             seg_end;
    logic             tab_we;

    // Table is read combinationally at the active segment.
    assign cur_half = half_tab[seg_idx];
    assign cur_rep  = (rep_tab[seg_idx] == '0) ? REP_W'(1) : rep_tab[seg_idx];

    // The counter is compared before it advances, so it never exceeds H and
    // cannot overflow. tcnt stays below cur_rep, so tcnt+1 cannot wrap.
    assign half_hit = (cnt == cur_half);
    assign seg_end  = ((tcnt + REP_W'(1)) == cur_rep);

    assign tab_we   = cfg_we && (state == S_IDLE);
    assign busy     = (state == S_RUN);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        seg_n   = seg_idx;
        sig_n   = sig_out;
        com_n   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && locked && !stop) begin
                    state_n = S_RUN;
                    seg_n   = '0;
                    cnt_n   = '0;
                    tcnt_n  = '0;
                    sig_n   = IDLE_LEVEL;
                end
            end

            S_RUN: begin
                // A write attempt during a run is flagged even if the run
                // is also being terminated in the same cycle.
                err_n = cfg_we;
                if (stop || !locked) begin
                    // Termination beats a coincident terminal toggle.
                    state_n = S_IDLE;
                    sig_n   = IDLE_LEVEL;
                    seg_n   = '0;
                    cnt_n   = '0;
                    tcnt_n  = '0;
                    if (!locked) begin
                        err_n = 1'b1;
                    end
                end else if (half_hit) begin
                    cnt_n = '0;
                    sig_n = ~sig_out;
                    if (seg_end) begin
                        tcnt_n = '0;
                        com_n  = 1'b1;
                        if (seg_idx != cfg_last) begin
                            seg_n = seg_idx + AW'(1);
                        end else if (loop_en) begin
                            seg_n = '0;
                        end else begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt + REP_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            tcnt    <= '0;
            seg_idx <= '0;
            sig_out <= IDLE_LEVEL;
            com     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tcnt    <= tcnt_n;
            seg_idx <= seg_n;
            sig_out <= sig_n;
            com     <= com_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                half_tab[i] <= '0;
                rep_tab[i]  <= '0;
            end
        end else if (tab_we) begin
            half_tab[cfg_addr] <= cfg_half;
            rep_tab[cfg_addr]  <= cfg_rep;
        end
    end

endmodule

// File: tb/tb_pw_sequencer.sv
module tb_pw_sequencer;

    localparam int   CNT_W = 8;
    localparam int   REP_W = 4;
    localparam int   DEPTH = 4;
    localparam int   AW    = 2;
    localparam logic IDLE  = 1'b1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             locked = 1'b0;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [REP_W-1:0] cfg_rep = '0;
    logic [AW-1:0]    cfg_last = '0;
    logic             loop_en = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             sig_out;
    logic             com;
    logic [AW-1:0]    seg_idx;
    logic             busy;
    logic             done;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    pw_sequencer #(
        .CNT_W(CNT_W), .REP_W(REP_W), .DEPTH(DEPTH), .IDLE_LEVEL(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_half(cfg_half), .cfg_rep(cfg_rep),
        .cfg_last(cfg_last), .loop_en(loop_en), .start(start), .stop(stop),
        .sig_out(sig_out), .com(com), .seg_idx(seg_idx), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: event-time based. A run is a list of toggle instants;
    // each toggle schedules the next one H+1 cycles later, and a count of
    // toggles left in the segment decides when the segment boundary falls.
    int   t = 0;
    int   mh [DEPTH];
    int   mr [DEPTH];
    logic m_busy = 1'b0;
    logic m_sig  = IDLE;
    int   m_seg  = 0;
    int   m_next = 0;
    int   m_left = 0;
    logic m_com  = 1'b0;
    logic m_done = 1'b0;
    logic m_err  = 1'b0;

    function automatic int eff(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    always @(posedge clk) begin
        t++;
        m_com  = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mh[i] = 0;
                mr[i] = 0;
            end
            m_busy = 1'b0;
            m_sig  = IDLE;
            m_seg  = 0;
        end else if (m_busy) begin
            if (cfg_we) m_err = 1'b1;
            if (stop || !locked) begin
                m_busy = 1'b0;
                m_sig  = IDLE;
                m_seg  = 0;
                if (!locked) m_err = 1'b1;
            end else if (t == m_next) begin
                m_sig  = ~m_sig;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_com = 1'b1;
                    if (m_seg != int'(cfg_last)) m_seg = m_seg + 1;
                    else if (loop_en) m_seg = 0;
                    else begin
                        m_done = 1'b1;
                        m_busy = 1'b0;
                    end
                    if (m_busy) m_left = eff(mr[m_seg]);
                end
                if (m_busy) m_next = t + mh[m_seg] + 1;
            end
        end else begin
            if (cfg_we) begin
                mh[cfg_addr] = int'(cfg_half);
                mr[cfg_addr] = int'(cfg_rep);
            end
            if (start && locked && !stop) begin
                m_busy = 1'b1;
                m_seg  = 0;
                m_sig  = IDLE;
                m_next = t + mh[0] + 1;
                m_left = eff(mr[0]);
            end
        end
    end

    always @(posedge clk) begin
        #3;
        check("sig_out", sig_out, m_sig);
        check("com", com, m_com);
        check("seg_idx", seg_idx, m_seg);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("err", err, m_err);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_entry(input int a, input int h, input int r);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_half = CNT_W'(h);
        cfg_rep  = REP_W'(r);
        tick(1);
        cfg_we = 1'b0;
    endtask

    // Leaves the caller at the negedge right after the start edge k.
    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        locked = 1'b1;
        repeat (3) begin
            tick(1);
            check("rst_sig", sig_out, 1);
            check("rst_busy", busy, 0);
            check("rst_seg", seg_idx, 0);
            check("rst_pulses", {com, done, err}, 0);
        end
        rst = 1'b1;
        tick(1);

        // Cleared entry 0 (H=0, rep=0): one toggle at k+1.
        cfg_last = 0;
        loop_en  = 1'b0;
        start_run();
        check("rb_busy_k", busy, 1);
        check("rb_sig_k", sig_out, 1);
        tick(1);
        check("rb_sig_k1", sig_out, 0);
        check("rb_done_k1", done, 1);
        check("rb_busy_k1", busy, 0);

        // Single segment H=3 rep=2: toggles at 4 and 8, com/done at 8.
        write_entry(0, 3, 2);
        start_run();
        tick(3);
        check("ss_sig3", sig_out, 1);
        tick(1);
        check("ss_sig4", sig_out, 0);
        check("ss_com4", com, 0);
        tick(4);
        check("ss_sig8", sig_out, 1);
        check("ss_com8", com, 1);
        check("ss_done8", done, 1);
        check("ss_busy8", busy, 0);
        // Restart in the cycle right after done.
        start_run();
        check("ss_restart", busy, 1);
        stop_run();
        check("ss_stop_busy", busy, 0);
        check("ss_stop_err", err, 0);

        // Stop at edge 3 and at edge 8 (stop beats the terminal toggle).
        start_run();
        tick(2);
        stop_run();
        check("st3_sig", sig_out, 1);
        check("st3_busy", busy, 0);
        start_run();
        tick(7);
        check("st8_pre_sig", sig_out, 0);
        stop_run();
        check("st8_sig", sig_out, 1);
        check("st8_busy", busy, 0);
        check("st8_comdone", {com, done}, 0);

        // Looping two segments.
        write_entry(0, 1, 2);
        write_entry(1, 2, 1);
        cfg_last = 1;
        loop_en  = 1'b1;
        start_run();
        tick(2);
        check("lp_sig2", sig_out, 0);
        check("lp_com2", com, 0);
        tick(2);
        check("lp_sig4", sig_out, 1);
        check("lp_com4", com, 1);
        check("lp_seg4", seg_idx, 1);
        tick(3);
        check("lp_sig7", sig_out, 0);
        check("lp_com7", com, 1);
        check("lp_seg7", seg_idx, 0);
        // Abort by losing lock.
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        check("ab_err", err, 1);
        check("ab_sig", sig_out, 1);
        check("ab_busy", busy, 0);
        tick(1);
        check("ab_err_clr", err, 0);

        // Rejected write during a run.
        start_run();
        tick(1);
        write_entry(1, 7, 3);
        check("wr_err", err, 1);
        check("wr_busy", busy, 1);
        stop_run();
        loop_en = 1'b0;
        start_run();
        tick(7);
        check("wr_old_done", done, 1);
        check("wr_old_seg", seg_idx, 1);

        // rep=0 behaves as one toggle.
        cfg_last = 0;
        write_entry(0, 2, 0);
        start_run();
        tick(2);
        check("r0_sig2", sig_out, 1);
        tick(1);
        check("r0_sig3", sig_out, 0);
        check("r0_comdone", {com, done}, 2'b11);
        check("r0_busy", busy, 0);

        // Randomized phase against the model.
        repeat (4000) begin
            rst      = ($urandom_range(0, 599) != 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = AW'($urandom_range(0, DEPTH - 1));
            cfg_half = CNT_W'($urandom_range(0, 4));
            cfg_rep  = REP_W'($urandom_range(0, 3));
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            locked   = ($urandom_range(0, 99) != 0);
            if (!busy && $urandom_range(0, 9) == 0) cfg_last = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
            tick(1);
        end
        rst    = 1'b1;
        cfg_we = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        locked = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
